// File: rtl/block_serial_subtractor.sv
// block_serial_subtractor
//   Multi-cycle two's-complement subtractor: diff = a - b - bin (mod 2^N).
//   Works on one BLK-bit block per clock, LSB block first. Each block uses a
//   ripple adder over a + ~b + carry. The carry to the next block goes through
//   a skip mux: when every bit of the block propagates, the incoming carry
//   bypasses the block.
//   Operands are taken over a valid/ready handshake. The result is held
//   behind out_valid until the consumer accepts it.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
//   both 1. in_ready is 1 only in IDLE. out_valid is 1 only in DONE. While
//   DONE waits for out_ready, the result stays frozen.
//
// Ports
//   clk        in   1  rising-edge clock
//   rst        in   1  asynchronous active-high reset
//   in_valid   in   1  operands a, b, bin valid
//   in_ready   out  1  block can accept operands
//   a          in   N  minuend
//   b          in   N  subtrahend
//   bin        in   1  borrow in
//   out_valid  out  1  diff, bout, overflow valid
//   out_ready  in   1  consumer accepts result
//   diff       out  N  a - b - bin, mod 2^N
//   bout       out  1  borrow out (unsigned a < b + bin)
//   overflow   out  1  signed overflow
//   state_dbg  out  2  current FSM state (0 IDLE, 1 BUSY, 2 DONE)
module block_serial_subtractor #(
  parameter int N   = 32,
  parameter int BLK = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         overflow,
  output logic [1:0]   state_dbg
);

  localparam int NB = N / BLK;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  if (((N % BLK) != 0) || (N < 2 * BLK)) begin : g_bad_param
    $error("block_serial_subtractor: N must be a multiple of BLK and >= 2*BLK");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [CW-1:0] blk_cnt_q;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic          carry_q;
  logic [N-1:0]  diff_q;
  logic          bout_q;
  logic          ovf_q;
  logic          out_valid_q;

  // Current block slice of the latched operands.
  logic [N-1:0]   a_sh;
  logic [N-1:0]   b_sh;
  logic [BLK-1:0] a_k;
  logic [BLK-1:0] nb_k;
  logic [BLK-1:0] p_k;
  logic [BLK:0]   c;
  logic [BLK-1:0] blk_sum_d;
  logic           carry_d;

  always_comb begin
    a_sh = a_q >> (blk_cnt_q * BLK);
    b_sh = b_q >> (blk_cnt_q * BLK);
    a_k  = a_sh[BLK-1:0];
    nb_k = ~b_sh[BLK-1:0];
    p_k  = a_k ^ nb_k;
    c    = '0;
    c[0] = carry_q;
    blk_sum_d = '0;
    for (int i = 0; i < BLK; i++) begin
      blk_sum_d[i] = p_k[i] ^ c[i];
      c[i+1]       = (a_k[i] & nb_k[i]) | (c[i] & p_k[i]);
    end
    // Skip mux: when all bits propagate, the block carry-out equals its carry-in.
    carry_d = (&p_k) ? carry_q : c[BLK];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      blk_cnt_q   <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q       <= a;
            b_q       <= b;
            carry_q   <= ~bin;  // a - b - bin = a + ~b + (1 - bin)
            blk_cnt_q <= '0;
            state_q   <= BUSY;
          end
        end
        BUSY: begin
          diff_q[blk_cnt_q*BLK +: BLK] <= blk_sum_d;
          carry_q <= carry_d;
          if (blk_cnt_q == CW'(NB - 1)) begin
            bout_q      <= ~carry_d;
            ovf_q       <= c[BLK-1] ^ carry_d;  // carry into MSB vs carry out
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            blk_cnt_q <= blk_cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign overflow  = ovf_q;
  assign state_dbg = state_q;

endmodule
